// File: rtl/sbox_layer_sched.sv
// rtl/sbox_layer_sched.sv - folded ASCON p_S layer, NB_SBOX columns per cycle; optional SBOX_SCHED_CST_EN merges p_C into load
// Bit 0 of every 5-bit sbox word is x0, bit 4 is x4.

module sbox (
    input  logic [4:0] sbox_i,
    output logic [4:0] sbox_o
);
    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    logic b0, b1, b2, b3, b4;

    // Bitsliced ASCON chi-like substitution, applied to one column
    always_comb begin
        a0 = sbox_i[0] ^ sbox_i[4];
        a4 = sbox_i[4] ^ sbox_i[3];
        a2 = sbox_i[2] ^ sbox_i[1];
        a1 = sbox_i[1];
        a3 = sbox_i[3];
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        sbox_o[1] = b1 ^ b0;
        sbox_o[0] = b0 ^ b4;
        sbox_o[3] = b3 ^ b2;
        sbox_o[2] = ~b2;
        sbox_o[4] = b4;
    end
endmodule

module sbox_layer_sched #(
    parameter int NB_SBOX = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [4:0][63:0] state_i,
`ifdef SBOX_SCHED_CST_EN
    input  logic [7:0]       cst_i,
`endif
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o
);
    localparam int NGRP = 64 / NB_SBOX;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

    if (NB_SBOX < 1 || NB_SBOX > 64 || (64 % NB_SBOX) != 0) begin : g_bad_nb
        $error("sbox_layer_sched: NB_SBOX must divide 64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    st_t              st_q;
    logic [CW-1:0]    grp_q;
    logic [4:0][63:0] state_q;
    logic [4:0][63:0] state_nxt;
    logic [4:0][63:0] load_val;
    logic [5:0]       base;
    logic [4:0]       lane_in  [NB_SBOX];
    logic [4:0]       lane_out [NB_SBOX];

    assign base = 6'(int'(grp_q) * NB_SBOX);

    always_comb begin
        for (int k = 0; k < NB_SBOX; k++) begin
            for (int w = 0; w < 5; w++) begin
                lane_in[k][w] = state_q[w][base + 6'(k)];
            end
        end
    end

    for (genvar k = 0; k < NB_SBOX; k++) begin : g_lane
        sbox u_sbox (
            .sbox_i (lane_in[k]),
            .sbox_o (lane_out[k])
        );
    end

    // Only the active column group is rewritten; all other columns pass through
    always_comb begin
        state_nxt = state_q;
        for (int k = 0; k < NB_SBOX; k++) begin
            for (int w = 0; w < 5; w++) begin
                state_nxt[w][base + 6'(k)] = lane_out[k][w];
            end
        end
    end

    always_comb begin
        load_val = state_i;
`ifdef SBOX_SCHED_CST_EN
        load_val[2][7:0] = state_i[2][7:0] ^ cst_i;
`endif
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            st_q    <= IDLE;
            grp_q   <= '0;
            state_q <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (st_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        st_q    <= RUN;
                        grp_q   <= '0;
                        state_q <= load_val;
                        busy_o  <= 1'b1;
                        valid_o <= 1'b0;
                    end else begin
                        st_q <= IDLE;
                    end
                end
                RUN: begin
                    if (en_i) begin
                        state_q <= state_nxt;
                        if (grp_q == LAST_GRP) begin
                            st_q    <= DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            valid_o <= 1'b1;
                        end else begin
                            grp_q <= grp_q + 1'b1;
                        end
                    end
                end
                default: begin
                    st_q   <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_sbox_layer_sched.sv
// tb/tb_sbox_layer_sched.sv - directed bench for sbox_layer_sched at NB_SBOX = 1, 4, 64
module tb_sbox_layer_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic en;
    logic [4:0][63:0] state_in;
`ifdef SBOX_SCHED_CST_EN
    logic [7:0] cst;
`endif
    logic [4:0][63:0] so4, so1, so64;
    logic busy4, done4, valid4;
    logic busy1, done1, valid1;
    logic busy64, done64, valid64;

    int n_cmp = 0;
    int n_fail = 0;

    logic [4:0][63:0] e_zero, e_ones, e_col5, in_col5, in_ones;

    always #5 clk = ~clk;

    sbox_layer_sched #(.NB_SBOX(4)) dut (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .en_i(en), .state_i(state_in),
`ifdef SBOX_SCHED_CST_EN
        .cst_i(cst),
`endif
        .state_o(so4), .busy_o(busy4), .done_o(done4), .valid_o(valid4));

    sbox_layer_sched #(.NB_SBOX(1)) dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .en_i(en), .state_i(state_in),
`ifdef SBOX_SCHED_CST_EN
        .cst_i(cst),
`endif
        .state_o(so1), .busy_o(busy1), .done_o(done1), .valid_o(valid1));

    sbox_layer_sched #(.NB_SBOX(64)) dut64 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .en_i(en), .state_i(state_in),
`ifdef SBOX_SCHED_CST_EN
        .cst_i(cst),
`endif
        .state_o(so64), .busy_o(busy64), .done_o(done64), .valid_o(valid64));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [4:0][63:0] s);
        state_in = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done4(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done4 && cnt < budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (so4 !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", so4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done4); end
        n_cmp++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid4); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int cnt;
        kick('0);
        n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy4); end
        wait_done4(200, cnt);
        n_cmp++; if (cnt !== 16) begin n_fail++; $display("FAIL zero_latency: got %0d want 16", cnt); end
        n_cmp++; if (so4 !== e_zero) begin n_fail++; $display("FAIL zero_result: got %h want %h", so4, e_zero); end
        n_cmp++; if (valid4 !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", valid4); end
        tick();
        n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done4); end
        tick();
        n_cmp++; if (valid4 !== 1'b1) begin n_fail++; $display("FAIL zero_valid_hold: got %b want 1", valid4); end
    endtask

    task automatic test_ones();
        int cnt;
        kick(in_ones);
        n_cmp++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL ones_valid_clear: got %b want 0", valid4); end
        wait_done4(200, cnt);
        n_cmp++; if (so4 !== e_ones) begin n_fail++; $display("FAIL ones_result: got %h want %h", so4, e_ones); end
    endtask

    task automatic test_col5();
        int cnt;
        kick(in_col5);
        wait_done4(200, cnt);
        n_cmp++; if (so4 !== e_col5) begin n_fail++; $display("FAIL col5_result: got %h want %h", so4, e_col5); end
        tick();
    endtask

    task automatic test_stall();
        int cnt;
        kick(in_col5);
        cnt = 0;
        while (!done4 && cnt < 200) begin
            en = !(cnt >= 5 && cnt < 8);
            start = (cnt == 10);
            tick();
            cnt++;
        end
        en = 1'b1;
        start = 1'b0;
        n_cmp++; if (cnt !== 19) begin n_fail++; $display("FAIL stall_latency: got %0d want 19", cnt); end
        n_cmp++; if (so4 !== e_col5) begin n_fail++; $display("FAIL stall_result: got %h want %h", so4, e_col5); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cnt;
        kick('0);
        wait_done4(200, cnt);
        n_cmp++; if (so4 !== e_zero) begin n_fail++; $display("FAIL b2b_first: got %h want %h", so4, e_zero); end
        state_in = in_ones;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b want 0", valid4); end
        n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy4); end
        wait_done4(200, cnt);
        n_cmp++; if (cnt !== 16) begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", cnt); end
        n_cmp++; if (so4 !== e_ones) begin n_fail++; $display("FAIL b2b_second: got %h want %h", so4, e_ones); end
        tick();
    endtask

    task automatic test_reset_mid();
        kick(in_ones);
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre: got %b want 1", busy4); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy4); end
        n_cmp++; if (so4 !== '0) begin n_fail++; $display("FAIL rstmid_state: got %h want 0", so4); end
        n_cmp++; if (valid4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b want 00", valid4, done4); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b want 0", busy4); end
    endtask

    task automatic test_sweep();
        int lat1, lat4, lat64;
        logic [4:0][63:0] r1, r64;
        lat1 = -1; lat4 = -1; lat64 = -1;
        r1 = '0; r64 = '0;
        kick(in_col5);
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (done1 && lat1 < 0) begin lat1 = c; r1 = so1; end
            if (done4 && lat4 < 0) lat4 = c;
            if (done64 && lat64 < 0) begin lat64 = c; r64 = so64; end
        end
        n_cmp++; if (lat1 !== 64) begin n_fail++; $display("FAIL sweep_lat1: got %0d want 64", lat1); end
        n_cmp++; if (lat4 !== 16) begin n_fail++; $display("FAIL sweep_lat4: got %0d want 16", lat4); end
        n_cmp++; if (lat64 !== 1) begin n_fail++; $display("FAIL sweep_lat64: got %0d want 1", lat64); end
        n_cmp++; if (r1 !== e_col5) begin n_fail++; $display("FAIL sweep_res1: got %h want %h", r1, e_col5); end
        n_cmp++; if (r64 !== e_col5) begin n_fail++; $display("FAIL sweep_res64: got %h want %h", r64, e_col5); end
    endtask

`ifdef SBOX_SCHED_CST_EN
    task automatic test_cst();
        int cnt;
        logic [4:0][63:0] e_cst;
        e_cst[0] = 64'hF0;
        e_cst[1] = 64'hF0;
        e_cst[2] = 64'hFFFF_FFFF_FFFF_FF0F;
        e_cst[3] = 64'hF0;
        e_cst[4] = 64'h0;
        cst = 8'hF0;
        kick('0);
        cst = 8'h00;
        wait_done4(200, cnt);
        n_cmp++; if (so4 !== e_cst) begin n_fail++; $display("FAIL cst_result: got %h want %h", so4, e_cst); end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        en = 1'b1;
        state_in = '0;
`ifdef SBOX_SCHED_CST_EN
        cst = 8'h00;
`endif
        e_zero = '0;
        e_zero[2] = '1;
        in_ones = '1;
        e_ones = '1;
        e_ones[1] = '0;
        in_col5 = '0;
        in_col5[4] = 64'h20;
        e_col5[0] = 64'h0;
        e_col5[1] = 64'h20;
        e_col5[2] = 64'hFFFF_FFFF_FFFF_FFDF;
        e_col5[3] = 64'h20;
        e_col5[4] = 64'h20;

        test_reset();
        test_zero();
        test_ones();
        test_col5();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
`ifdef SBOX_SCHED_CST_EN
        test_cst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
